qr_grid_sampler: RTL and testbench

Parametrised grid sampler that turns a located QR symbol in the frame buffer into a bit matrix. It supports symbol versions 1..MAX_VERSION, a configurable pixel-memory read latency, 5-point majority voting per module and frame-bounds checking. It sits between the finder-pattern locator (origin and module size) and the QR decoder, and reads pixels through the same 1-bit thresholded frame-buffer port used elsewhere in the pipeline.

---
 rtl/qr_pkg.sv | 33 +++
 rtl/qr_sample_addr.sv | 54 +++++
 rtl/qr_grid_sampler.sv | 192 +++++++++++++++++++
 tb/tb_qr_grid_sampler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared types and size helpers for the QR sampling/decoding path.
//   sampler_state_e : grid sampler FSM states
//   sample_off_e    : which of the five vote points is being read (k)
//   QR_SIZE()       : symbol edge length in modules for a version
//   QR_MAX_SIZE     : edge length of the largest symbol the pipeline carries
package qr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DECIDE,
    S_DONE
  } sampler_state_e;

  // Order is the read order within a module: centre, left, right, up, down.
  typedef enum logic [2:0] {
    OFF_C = 3'd0,
    OFF_L = 3'd1,
    OFF_R = 3'd2,
    OFF_U = 3'd3,
    OFF_D = 3'd4
  } sample_off_e;

  function automatic int QR_SIZE(input int version);
    return 17 + 4 * version;
  endfunction

  localparam int QR_MAX_VERSION = 6;
  localparam int QR_MAX_SIZE    = 17 + 4 * QR_MAX_VERSION;

endpackage

// File: rtl/qr_sample_addr.sv
// Frame-buffer address generator for one vote point.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   en               : load read_addr this cycle
//   min_x, min_y     : centre of module (0,0), signed pixels
//   x, y             : module coordinates
//   k                : vote point (sample_off_e encoding)
//   module_size, q   : module pitch and vote-point offset
//   read_addr        : registered px + py*WIDTH
// Kept separate so the multipliers can be pipelined without touching the FSM.
module qr_sample_addr
  import qr_pkg::*;
#(
  parameter int WIDTH = 480,
  parameter int XY_W  = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en,
  input  logic signed [15:0]  min_x,
  input  logic signed [15:0]  min_y,
  input  logic [XY_W-1:0]     x,
  input  logic [XY_W-1:0]     y,
  input  logic [2:0]          k,
  input  logic [8:0]          module_size,
  input  logic [8:0]          q,
  output logic [19:0]         read_addr
);

  logic signed [15:0] cx, cy, qs, px, py;
  logic [19:0]        addr_c;

  always_comb begin
    cx = min_x + $signed(16'(x) * 16'(module_size));
    cy = min_y + $signed(16'(y) * 16'(module_size));
    qs = $signed(16'(q));
    px = cx;
    py = cy;
    case (sample_off_e'(k))
      OFF_L:   px = cx - qs;
      OFF_R:   px = cx + qs;
      OFF_U:   py = cy - qs;
      OFF_D:   py = cy + qs;
      default: ;
    endcase
    // Bounds were checked before any read, so px/py are non-negative here.
    addr_c = 20'(px) + 20'(py) * 20'(WIDTH);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)  read_addr <= '0;
    else if (en) read_addr <= addr_c;
  end

endmodule

// File: rtl/qr_grid_sampler.sv
// Samples a located QR symbol out of the 1-bit frame buffer into a bit matrix.
// Each module is read at five points (centre, +/-q in x and y) and decided by
// majority vote.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   start_in              : request, accepted only when idle
//   version_in            : symbol version, N = 17 + 4*version_in
//   module_size           : module pitch in pixels
//   origin_x, origin_y    : centre of the top-left finder pattern
//   pixel_in              : pixel returned READ_LATENCY cycles after read_en
//   read_addr, read_en    : frame-buffer read port
//   qr_code               : module bit at x + y*N, unused bits 0
//   busy                  : request in progress
//   valid_qr / error      : one-cycle completion / rejection pulse
module qr_grid_sampler
  import qr_pkg::*;
#(
  parameter  int MAX_VERSION  = 6,
  parameter  int WIDTH        = 480,
  parameter  int HEIGHT       = 320,
  parameter  int READ_LATENCY = 2,
  localparam int MAX_SIZE     = QR_SIZE(MAX_VERSION)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [2:0]                   version_in,
  input  logic [8:0]                   module_size,
  input  logic [8:0]                   origin_x,
  input  logic [8:0]                   origin_y,
  input  logic                         pixel_in,
  output logic [19:0]                  read_addr,
  output logic                         read_en,
  output logic [MAX_SIZE*MAX_SIZE-1:0] qr_code,
  output logic                         busy,
  output logic                         valid_qr,
  output logic                         error
);

  // version_in is 3 bits, so N never exceeds QR_SIZE(7) = 45.
  localparam int XY_W      = 6;
  localparam int IDX_W     = $clog2(MAX_SIZE * MAX_SIZE);
  localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic signed [15:0] W_S = 16'(WIDTH);
  localparam logic signed [15:0] H_S = 16'(HEIGHT);

  sampler_state_e        state, state_nxt;
  sample_off_e           k, k_nxt;
  logic [XY_W-1:0]       x, y, x_nxt, y_nxt;
  logic [2:0]            ver_r;
  logic [8:0]            ms_r, ox_r, oy_r;
  logic [XY_W-1:0]       n_r;
  logic [7:0]            wcnt;
  logic [IDX_W-1:0]      idx;
  logic [2:0]            votes, vote_sum;
  logic [READ_LATENCY:1] vld_pipe;

  // Geometry is 16-bit signed so (N-1)*module_size cannot wrap.
  logic signed [15:0] min_x, min_y, max_x, max_y, q_s;
  logic [15:0]        span;
  logic               reject, last_col, last_mod, sample_hit;

  always_comb begin
    q_s    = $signed(16'(ms_r >> 2));
    min_x  = $signed({7'b0, ox_r}) - 16'sd3 * $signed({7'b0, ms_r});
    min_y  = $signed({7'b0, oy_r}) - 16'sd3 * $signed({7'b0, ms_r});
    span   = 16'(n_r - 6'd1) * 16'(ms_r);
    max_x  = min_x + $signed(span);
    max_y  = min_y + $signed(span);
    reject = (ver_r == 3'd0) || (int'(ver_r) > MAX_VERSION) || (ms_r == 9'd0) ||
             ((min_x - q_s) < 16'sd0) || ((min_y - q_s) < 16'sd0) ||
             ((max_x + q_s) >= W_S)   || ((max_y + q_s) >= H_S);
  end

  assign last_col   = (x == n_r - 6'd1);
  assign last_mod   = last_col && (y == n_r - 6'd1);
  // Only pixels that line up with a tracked read may vote.
  assign sample_hit = vld_pipe[READ_LATENCY] & pixel_in;
  assign vote_sum   = votes + {2'b0, sample_hit};

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    k_nxt     = k;
    case (state)
      S_IDLE: if (start_in) begin
        state_nxt = S_CHECK;
        x_nxt     = '0;
        y_nxt     = '0;
        k_nxt     = OFF_C;
      end
      S_CHECK: begin
        k_nxt     = OFF_C;
        state_nxt = reject ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (k == OFF_D) state_nxt = (READ_LATENCY == 1) ? S_DECIDE : S_WAIT;
        else            k_nxt     = sample_off_e'(k + 3'd1);
      end
      S_WAIT: if (wcnt == 8'(WAIT_LAST)) state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (last_mod) state_nxt = S_DONE;
        else begin
          state_nxt = S_ISSUE;
          k_nxt     = OFF_C;
          if (last_col) begin
            x_nxt = '0;
            y_nxt = y + 6'd1;
          end else begin
            x_nxt = x + 6'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      k        <= OFF_C;
      x        <= '0;
      y        <= '0;
      ver_r    <= '0;
      ms_r     <= '0;
      ox_r     <= '0;
      oy_r     <= '0;
      n_r      <= '0;
      wcnt     <= '0;
      idx      <= '0;
      votes    <= '0;
      vld_pipe <= '0;
      read_en  <= 1'b0;
      busy     <= 1'b0;
      valid_qr <= 1'b0;
      error    <= 1'b0;
      qr_code  <= '0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      // Outputs follow the next state so they line up with it on the wire.
      read_en  <= (state_nxt == S_ISSUE);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      valid_qr <= (state == S_DECIDE) && last_mod;
      error    <= (state == S_CHECK) && reject;
      wcnt     <= (state == S_WAIT) ? wcnt + 8'd1 : 8'd0;

      vld_pipe[1] <= read_en;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];

      if (state == S_IDLE || state == S_DECIDE) votes <= '0;
      else                                      votes <= vote_sum;

      if (state == S_IDLE && start_in) begin
        ver_r   <= version_in;
        ms_r    <= module_size;
        ox_r    <= origin_x;
        oy_r    <= origin_y;
        n_r     <= XY_W'(QR_SIZE(int'(version_in)));
        idx     <= '0;
        qr_code <= '0;
      end

      // Modules are visited in raster order, so x + y*N is just a running count.
      if (state == S_DECIDE) begin
        qr_code[idx] <= (vote_sum >= 3'd3);
        idx          <= idx + 1'b1;
      end
    end
  end

  qr_sample_addr #(
    .WIDTH (WIDTH),
    .XY_W  (XY_W)
  ) u_addr (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en          (state_nxt == S_ISSUE),
    .min_x       (min_x),
    .min_y       (min_y),
    .x           (x_nxt),
    .y           (y_nxt),
    .k           (k_nxt),
    .module_size (ms_r),
    .q           (ms_r >> 2),
    .read_addr   (read_addr)
  );

endmodule

// File: tb/tb_qr_grid_sampler.sv
// Bench for qr_grid_sampler: three instances (READ_LATENCY 1, 2, 3) share the
// request inputs; each has its own delayed frame-buffer model. Expected matrix
// bits come from the painted image; read timing/addresses from the sampling rules.
module tb_qr_grid_sampler;

  localparam int W = 480, H = 320, MAXV = 6, MS = 41, QW = MS * MS, NI = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] ver = '0;
  logic [8:0] msz = '0, ox = '0, oy = '0;
  logic [NI-1:0] pix_w, ren_w, busy_w, valid_w, err_w;
  logic [19:0]   raddr_w [NI];
  logic [QW-1:0] qr_w    [NI];

  bit frame [W*H];
  bit expq  [QW];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic mp [g+1];
    qr_grid_sampler #(.MAX_VERSION(MAXV), .WIDTH(W), .HEIGHT(H), .READ_LATENCY(g+1)) u_dut (
      .clk_in(clk), .rst_in(rst), .start_in(start), .version_in(ver),
      .module_size(msz), .origin_x(ox), .origin_y(oy), .pixel_in(pix_w[g]),
      .read_addr(raddr_w[g]), .read_en(ren_w[g]), .qr_code(qr_w[g]),
      .busy(busy_w[g]), .valid_qr(valid_w[g]), .error(err_w[g]));
    // Returns ones on idle cycles so unaligned vote counting shows up.
    always @(posedge clk) begin
      mp[0] <= ren_w[g] ? frame[raddr_w[g]] : 1'b1;
      for (int i = 1; i <= g; i++) mp[i] <= mp[i-1];
    end
    assign pix_w[g] = mp[g];
  end

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (L=%0d): got %0d, expected %0d", name, g + 1, act, exp);
    end
  endtask

  function automatic int samp_addr(input int oxi, oyi, msi, x, y, k);
    int q, cx, cy;
    q  = msi / 4;
    cx = oxi - 3 * msi + x * msi;
    cy = oyi - 3 * msi + y * msi;
    case (k)
      1: cx -= q;
      2: cx += q;
      3: cy -= q;
      4: cy += q;
      default: ;
    endcase
    return cx + cy * W;
  endfunction

  // Paint N*N random modules as solid squares; optionally flip 0..3 of a
  // module's five vote points (3 flips must invert the decided bit).
  task automatic paint(input int n, msi, oxi, oyi, input bit speckle);
    int cx, cy, px, py, nf, r;
    bit b;
    for (int m = 0; m < n * n; m++) begin
      b  = bit'($urandom_range(0, 1));
      cx = oxi - 3 * msi + (m % n) * msi;
      cy = oyi - 3 * msi + (m / n) * msi;
      for (int dy = 0; dy < msi; dy++)
        for (int dx = 0; dx < msi; dx++) begin
          px = cx - msi / 2 + dx;
          py = cy - msi / 2 + dy;
          if (px >= 0 && px < W && py >= 0 && py < H) frame[px + py * W] = b;
        end
      expq[m] = b;
      if (speckle) begin
        nf = $urandom_range(0, 3);
        r  = $urandom_range(0, 4);
        for (int i = 0; i < nf; i++) frame[samp_addr(oxi, oyi, msi, m % n, m / n, (r + i) % 5)] = ~b;
        expq[m] = b ^ (nf == 3);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NI; g++)
      chk(tag, g, int'(qr_w[g] != '0) + int'(busy_w[g]) + int'(valid_w[g]) + int'(err_w[g]) +
                  int'(ren_w[g]) + int'(raddr_w[g] != '0), 0);
  endtask

  task automatic run_scan(input string tag, input int vi, msi, oxi, oyi, input bit exp_err, input bit speckle);
    int n, lim, p, d, m, kk, diff;
    bit er;
    int first[NI], reads[NI], pat_bad[NI], addr_bad[NI], busy_bad[NI], pulse_bad[NI];
    n = 17 + 4 * vi;
    for (int i = 0; i < QW; i++) expq[i] = 1'b0;
    if (!exp_err) paint(n, msi, oxi, oyi, speckle);
    for (int g = 0; g < NI; g++) begin
      first[g] = -1; reads[g] = 0; pat_bad[g] = 0; addr_bad[g] = 0; busy_bad[g] = 0; pulse_bad[g] = 0;
    end
    @(negedge clk);
    ver = 3'(vi); msz = 9'(msi); ox = 9'(oxi); oy = 9'(oyi); start = 1'b1;
    lim = exp_err ? 8 : 2 + n * n * 8 + 4;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      for (int g = 0; g < NI; g++) begin
        p  = 6 + g;
        d  = exp_err ? 2 : 2 + n * n * p;
        er = !exp_err && c >= 2 && c < d && ((c - 2) % p) < 5;
        m  = (c - 2) / p;
        kk = (c - 2) % p;
        if (ren_w[g]) reads[g]++;
        if (ren_w[g] != er) pat_bad[g]++;
        else if (er && raddr_w[g] != 20'(samp_addr(oxi, oyi, msi, m % n, m / n, kk))) addr_bad[g]++;
        if (busy_w[g] != (c < d)) busy_bad[g]++;
        if (valid_w[g] != (!exp_err && c == d)) pulse_bad[g]++;
        if (err_w[g] != (exp_err && c == d)) pulse_bad[g]++;
        if ((valid_w[g] || err_w[g]) && first[g] < 0) first[g] = c;
      end
    end
    for (int g = 0; g < NI; g++) begin
      diff = 0;
      for (int i = 0; i < QW; i++) if (qr_w[g][i] != expq[i]) diff++;
      chk({tag, " done cycle"}, g, first[g], exp_err ? 2 : 2 + n * n * (6 + g));
      chk({tag, " read count"}, g, reads[g], exp_err ? 0 : 5 * n * n);
      chk({tag, " read_en pattern"}, g, pat_bad[g], 0);
      chk({tag, " read_addr seq"}, g, addr_bad[g], 0);
      chk({tag, " busy"}, g, busy_bad[g], 0);
      chk({tag, " valid/error pulse"}, g, pulse_bad[g], 0);
      chk({tag, " qr_code bits"}, g, diff, 0);
    end
  endtask

  typedef struct {
    int ver; int ms; int ox; int oy; bit err;
  } vec_t;

  initial begin
    vec_t tbl [14];
    int bad [NI];
    int p, n, q, lo, hi_x, hi_y, vi, msi, quiet;

    tbl = '{
      '{1, 4,  60,  60, 1'b0}, '{1, 4,  10,  60, 1'b1}, '{7, 4,  60,  60, 1'b1},
      '{0, 4,  60,  60, 1'b1}, '{1, 0,  60,  60, 1'b1}, '{1, 4, 410,  60, 1'b0},
      '{1, 4, 411,  60, 1'b1}, '{1, 4,  13,  60, 1'b0}, '{1, 4,  12,  60, 1'b1},
      '{1, 4,  60, 250, 1'b0}, '{1, 4,  60, 251, 1'b1}, '{6, 8,  60,  60, 1'b1},
      '{1, 1,   3,   3, 1'b0}, '{1, 1,   2,   3, 1'b1}};

    for (int i = 0; i < W * H; i++) frame[i] = bit'($urandom_range(0, 1));

    repeat (3) @(negedge clk);
    check_zero("reset state");
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_scan($sformatf("vec%0d", i), tbl[i].ver, tbl[i].ms, tbl[i].ox, tbl[i].oy, tbl[i].err, 1'b0);

    run_scan("v6 full", 6, 5, 60, 60, 1'b0, 1'b0);
    run_scan("speckle", 2, 5, 50, 50, 1'b0, 1'b1);

    // Second start while busy must not restart; then reset with reads in flight.
    for (int g = 0; g < NI; g++) bad[g] = 0;
    @(negedge clk);
    ver = 3'd1; msz = 9'd4; ox = 9'd60; oy = 9'd60; start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        p = 6 + g;
        if (ren_w[g] != (c >= 2 && ((c - 2) % p) < 5) || !busy_w[g]) bad[g]++;
        else if (ren_w[g] && raddr_w[g] != 20'(samp_addr(60, 60, 4, ((c - 2) / p) % 21,
                                                          ((c - 2) / p) / 21, (c - 2) % p))) bad[g]++;
      end
      if (c == 1)  start = 1'b0;
      if (c == 60) begin ox = 9'd100; oy = 9'd100; start = 1'b1; end
      if (c == 61) start = 1'b0;
    end
    for (int g = 0; g < NI; g++) chk("ignored start", g, bad[g], 0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset mid-scan");
    rst = 1'b0;
    for (int g = 0; g < NI; g++) bad[g] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) bad[g] += int'(busy_w[g] | valid_w[g] | err_w[g] | ren_w[g]);
    end
    for (int g = 0; g < NI; g++) chk("quiet after reset", g, bad[g], 0);
    run_scan("after reset", 1, 4, 60, 60, 1'b0, 1'b0);

    // Randomized placements inside the legal window, with speckle.
    for (int r = 0; r < 2; r++) begin
      vi   = $urandom_range(1, 2);
      msi  = $urandom_range(4, 6);
      n    = 17 + 4 * vi;
      q    = msi / 4;
      lo   = 3 * msi + q;
      hi_x = W - 1 - q - (n - 4) * msi;
      hi_y = H - 1 - q - (n - 4) * msi;
      run_scan($sformatf("random%0d", r), vi, msi, $urandom_range(lo, hi_x), $urandom_range(lo, hi_y),
               1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
